// File: rtl/cmd_pkg.sv
// Shared encodings for the command sequencer: pointer opcodes, command classes
// and FSM state encoding.
package cmd_pkg;

   localparam logic [2:0] PTR_NUL = 3'b000;
   localparam logic [2:0] PTR_JMP = 3'b001;
   localparam logic [2:0] PTR_SJF = 3'b010;
   localparam logic [2:0] PTR_SJB = 3'b100;

   localparam logic [2:0] CLS_EXE  = 3'b000;
   localparam logic [2:0] CLS_JMP  = 3'b001;
   localparam logic [2:0] CLS_SJF  = 3'b010;
   localparam logic [2:0] CLS_CALL = 3'b011;
   localparam logic [2:0] CLS_SJB  = 3'b100;
   localparam logic [2:0] CLS_RET  = 3'b101;
   localparam logic [2:0] CLS_RSV  = 3'b110;
   localparam logic [2:0] CLS_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_WAIT     = 3'd2,
      S_DISPATCH = 3'd3,
      S_EXEC     = 3'd4,
      S_HALT     = 3'd5,
      S_RESUME   = 3'd6,
      S_FAULT    = 3'd7
   } state_t;

endpackage

// File: rtl/cmd_ret_stack.sv
// Hardware return stack: register array indexed by an occupancy counter.
// Push on full and pop on empty are ignored; the caller turns them into a fault.
module cmd_ret_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      sp_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    top_idx;

   assign full     = (sp_q == (AW+1)'(DEPTH));
   assign empty    = (sp_q == '0);
   assign top_idx  = sp_q[AW-1:0] - AW'(1);
   assign top_data = mem_q[top_idx];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sp_q <= '0;
      end else if (push && !full) begin
         sp_q <= sp_q + (AW+1)'(1);
      end else if (pop && !empty) begin
         sp_q <= sp_q - (AW+1)'(1);
      end
   end

   // Entries need no reset: they are only read below the occupancy count.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[sp_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/cmd_seq_ctrl.sv
// Fetch/dispatch sequencer driving the command pointer, the command memory
// port and the execute-unit handshake; owns the return stack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, pointer held, waiting for ptr_ready & run
// FETCH    | first request cycle, mem_addr taken from ptr_addr
// WAIT     | request held with latched address until mem_ack
// DISPATCH | decode latched word, issue branch/call/return to pointer
// EXEC     | offer EXE word to execute unit; step pointer on handshake
// HALT     | halted=1, pointer held until run
// RESUME   | one NUL cycle stepping past the HALT word
// FAULT    | sticky error, pointer held until reset
module cmd_seq_ctrl
   import cmd_pkg::*;
#(
   parameter int                   BUS_WIDTH   = 32,
   parameter logic [BUS_WIDTH-1:0] PTR_BASE    = '0,
   parameter int                   STACK_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 run,
   input  logic [BUS_WIDTH-1:0] ptr_addr,
   input  logic                 ptr_ready,
   output logic [2:0]           ptr_opcode,
   output logic [BUS_WIDTH-1:0] ptr_addr_to,
   output logic                 mem_req,
   output logic [BUS_WIDTH-1:0] mem_addr,
   input  logic                 mem_ack,
   input  logic [BUS_WIDTH-1:0] mem_data,
   output logic                 exe_valid,
   output logic [BUS_WIDTH-1:0] exe_instr,
   input  logic                 exe_ready,
   output logic                 halted,
   output logic                 fault
);

   state_t               state_q, state_d;
   logic [BUS_WIDTH-1:0] instr_q;
   logic [BUS_WIDTH-1:0] addr_q;
   logic [2:0]           cls;
   logic [BUS_WIDTH-1:0] operand;
   logic [BUS_WIDTH-1:0] hold_addr;
   logic [BUS_WIDTH-1:0] ret_addr;
   logic                 push, pop, stk_full, stk_empty;
   logic [BUS_WIDTH-1:0] stk_top;

   assign cls       = instr_q[BUS_WIDTH-1 -: 3];
   assign operand   = {3'b000, instr_q[BUS_WIDTH-4:0]};
   assign hold_addr = ptr_addr - PTR_BASE;
   assign ret_addr  = hold_addr + BUS_WIDTH'(1);

   cmd_ret_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (BUS_WIDTH)
   ) u_stack (
      .clk       (clk),
      .nreset    (nreset),
      .push      (push),
      .pop       (pop),
      .push_data (ret_addr),
      .top_data  (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH) addr_q <= ptr_addr;
         if ((state_q == S_FETCH || state_q == S_WAIT) && mem_ack) instr_q <= mem_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (ptr_ready && run) state_d = S_FETCH;
         S_FETCH:  state_d = mem_ack ? S_DISPATCH : S_WAIT;
         S_WAIT:   if (mem_ack) state_d = S_DISPATCH;
         S_DISPATCH: begin
            unique case (cls)
               CLS_EXE:  state_d = S_EXEC;
               CLS_CALL: state_d = stk_full  ? S_FAULT : S_FETCH;
               CLS_RET:  state_d = stk_empty ? S_FAULT : S_FETCH;
               CLS_HALT: state_d = S_HALT;
               CLS_RSV:  state_d = S_FAULT;
               default:  state_d = S_FETCH;
            endcase
         end
         S_EXEC:   if (exe_ready) state_d = S_FETCH;
         S_HALT:   if (run) state_d = S_RESUME;
         S_RESUME: state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   // The pointer moves every clock, so "hold" is a jump to its own address.
   always_comb begin
      ptr_opcode  = PTR_JMP;
      ptr_addr_to = hold_addr;
      push        = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         S_DISPATCH: begin
            unique case (cls)
               CLS_JMP: begin ptr_opcode = PTR_JMP; ptr_addr_to = operand; end
               CLS_SJF: begin ptr_opcode = PTR_SJF; ptr_addr_to = operand; end
               CLS_SJB: begin ptr_opcode = PTR_SJB; ptr_addr_to = operand; end
               CLS_CALL: if (!stk_full) begin
                  push        = 1'b1;
                  ptr_addr_to = operand;
               end
               CLS_RET: if (!stk_empty) begin
                  pop         = 1'b1;
                  ptr_addr_to = stk_top;
               end
               default: ;
            endcase
         end
         S_EXEC:   if (exe_ready) ptr_opcode = PTR_NUL;
         S_RESUME: ptr_opcode = PTR_NUL;
         default: ;
      endcase
   end

   assign mem_req   = (state_q == S_FETCH) || (state_q == S_WAIT);
   assign mem_addr  = (state_q == S_FETCH) ? ptr_addr : addr_q;
   assign exe_valid = (state_q == S_EXEC);
   assign exe_instr = instr_q;
   assign halted    = (state_q == S_HALT);
   assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_cmd_seq_ctrl.sv
// Bench for cmd_seq_ctrl: behavioural pointer and memory models plus
// queue-based scoreboard of fetch addresses, EXE words and pointer commands.
module tb_cmd_seq_ctrl;

   localparam int BW = 32;

   typedef struct packed {
      logic [2:0]    op;
      logic [BW-1:0] to;
   } pcmd_t;

   logic          clk = 1'b0;
   logic          nreset = 1'b0;
   logic          run = 1'b0;
   logic [BW-1:0] ptr_addr;
   logic          ptr_ready = 1'b1;
   logic [2:0]    ptr_opcode;
   logic [BW-1:0] ptr_addr_to;
   logic          mem_req;
   logic [BW-1:0] mem_addr;
   logic          mem_ack;
   logic [BW-1:0] mem_data;
   logic          exe_valid;
   logic [BW-1:0] exe_instr;
   logic          exe_ready;
   logic          halted;
   logic          fault;

   logic [BW-1:0] ptr_reg;
   logic [BW-1:0] mem_arr [256];
   int            ack_delay = 0;
   int            exe_delay = 0;
   int            wait_cnt, exe_cnt;
   logic          force_ack = 1'b0;

   logic [BW-1:0] fetch_q [$];
   logic [BW-1:0] exe_q   [$];
   pcmd_t         ptr_q   [$];

   int n_chk = 0;
   int n_pass = 0;

   logic          pend_mem = 1'b0, pend_exe = 1'b0;
   logic [BW-1:0] last_addr, last_instr;

   cmd_seq_ctrl #(.BUS_WIDTH(BW), .PTR_BASE('0), .STACK_DEPTH(8)) dut (
      .clk(clk), .nreset(nreset), .run(run), .ptr_addr(ptr_addr), .ptr_ready(ptr_ready),
      .ptr_opcode(ptr_opcode), .ptr_addr_to(ptr_addr_to), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .exe_valid(exe_valid), .exe_instr(exe_instr), .exe_ready(exe_ready),
      .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // Command pointer model: moves every clock according to the opcode.
   always @(posedge clk or negedge nreset) begin
      if (!nreset) ptr_reg <= '0;
      else case (ptr_opcode)
         3'b000:  ptr_reg <= ptr_reg + 1;
         3'b001:  ptr_reg <= ptr_addr_to;
         3'b010:  ptr_reg <= ptr_reg + ptr_addr_to;
         3'b100:  ptr_reg <= ptr_reg - ptr_addr_to;
         default: ptr_reg <= ptr_reg;
      endcase
   end
   assign ptr_addr = ptr_reg;

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wait_cnt <= 0;
         exe_cnt  <= 0;
      end else begin
         wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
         exe_cnt  <= (exe_valid && !exe_ready) ? exe_cnt + 1 : 0;
      end
   end
   assign mem_ack   = (mem_req && wait_cnt >= ack_delay) || force_ack;
   assign mem_data  = mem_arr[mem_addr[7:0]];
   assign exe_ready = exe_valid && exe_cnt >= exe_delay;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [BW-1:0] mk(input logic [2:0] c, input logic [28:0] o);
      return {c, o};
   endfunction

   // Scoreboard and handshake-stability monitor.
   always @(negedge clk) begin
      logic [BW-1:0] exp_w;
      pcmd_t         exp_p;
      if (!nreset) begin
         pend_mem = 1'b0;
         pend_exe = 1'b0;
      end else begin
         if (pend_mem) begin
            check("req_stable", {31'd0, mem_req}, 1);
            check("addr_stable", mem_addr, last_addr);
            check("ptr_hold_wait", {29'd0, ptr_opcode}, 3'b001);
         end
         if (pend_exe) begin
            check("valid_stable", {31'd0, exe_valid}, 1);
            check("instr_stable", exe_instr, last_instr);
         end
         pend_mem   = mem_req && !mem_ack;
         last_addr  = mem_addr;
         pend_exe   = exe_valid && !exe_ready;
         last_instr = exe_instr;
         if (mem_req && mem_ack) begin
            exp_w = fetch_q.size() > 0 ? fetch_q.pop_front() : 'x;
            check("fetch_addr", mem_addr, exp_w);
         end
         if (exe_valid && exe_ready) begin
            exp_w = exe_q.size() > 0 ? exe_q.pop_front() : 'x;
            check("exe_instr", exe_instr, exp_w);
         end
         if (!(ptr_opcode == 3'b001 && ptr_addr_to == ptr_addr)) begin
            exp_p = ptr_q.size() > 0 ? ptr_q.pop_front() : '{op: 3'bxxx, to: 'x};
            check("ptr_opcode", {29'd0, ptr_opcode}, {29'd0, exp_p.op});
            if (exp_p.op != 3'b000) check("ptr_addr_to", ptr_addr_to, exp_p.to);
         end
      end
   end

   task automatic do_reset();
      nreset = 1'b0;
      run = 1'b0;
      force_ack = 1'b0;
      ack_delay = 0;
      exe_delay = 0;
      fetch_q.delete();
      exe_q.delete();
      ptr_q.delete();
      for (int i = 0; i < 256; i++) mem_arr[i] = mk(3'b111, 29'd0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic start();
      @(negedge clk) run = 1'b1;
      @(negedge clk) run = 1'b0;
   endtask

   task automatic wait_stop(input int budget);
      int n = 0;
      while (!(halted || fault) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("stop_budget", {31'd0, (halted || fault)}, 1);
   endtask

   task automatic drained();
      check("fetch_left", fetch_q.size(), 0);
      check("exe_left", exe_q.size(), 0);
      check("ptr_left", ptr_q.size(), 0);
   endtask

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 0);
      check("rst_exe_valid", {31'd0, exe_valid}, 0);
      check("rst_halted", {31'd0, halted}, 0);
      check("rst_fault", {31'd0, fault}, 0);
      check("rst_opcode", {29'd0, ptr_opcode}, 3'b001);
      check("rst_addr_to", ptr_addr_to, 0);

      // Two EXE words, HALT held with run low, then resume past the HALT
      mem_arr[0] = mk(3'b000, 29'h123);
      mem_arr[1] = mk(3'b000, 29'h0ABCDEF);
      fetch_q = '{0, 1, 2};
      exe_q   = '{mk(3'b000, 29'h123), mk(3'b000, 29'h0ABCDEF)};
      ptr_q   = '{'{op: 3'b000, to: 0}, '{op: 3'b000, to: 0}};
      start();
      wait_stop(60);
      check("exe_halted", {31'd0, halted}, 1);
      repeat (5) @(negedge clk);
      check("halt_held", {31'd0, halted}, 1);
      check("halt_no_req", {31'd0, mem_req}, 0);
      check("halt_ptr", ptr_addr, 2);
      ptr_q.push_back('{op: 3'b000, to: 0});
      fetch_q.push_back(3);
      @(negedge clk) run = 1'b1;
      @(negedge clk) run = 1'b0;
      check("resume_halted", {31'd0, halted}, 0);
      wait_stop(20);
      check("resume_ptr", ptr_addr, 3);
      drained();

      // JMP
      do_reset();
      mem_arr[0] = mk(3'b001, 29'h10);
      fetch_q = '{0, 32'h10};
      ptr_q   = '{'{op: 3'b001, to: 32'h10}};
      start();
      wait_stop(30);
      drained();

      // CALL at 5 then RET
      do_reset();
      mem_arr[0]    = mk(3'b001, 29'h5);
      mem_arr[5]    = mk(3'b011, 29'h20);
      mem_arr[32'h20] = mk(3'b101, 29'h0);
      fetch_q = '{0, 5, 32'h20, 6};
      ptr_q   = '{'{op: 3'b001, to: 5}, '{op: 3'b001, to: 32'h20}, '{op: 3'b001, to: 6}};
      start();
      wait_stop(40);
      check("call_halted", {31'd0, halted}, 1);
      check("call_fault", {31'd0, fault}, 0);
      drained();

      // Nine nested CALLs overflow an 8-deep stack
      do_reset();
      mem_arr[0] = mk(3'b001, 29'h30);
      fetch_q.push_back(0);
      ptr_q.push_back('{op: 3'b001, to: 32'h30});
      for (int i = 0; i < 9; i++) begin
         mem_arr[8'h30 + i] = mk(3'b011, 29'(32'h31 + i));
         fetch_q.push_back(32'h30 + i);
         if (i < 8) ptr_q.push_back('{op: 3'b001, to: 32'h31 + i});
      end
      start();
      wait_stop(80);
      repeat (10) @(negedge clk);
      check("ovf_fault", {31'd0, fault}, 1);
      check("ovf_ptr_frozen", ptr_addr, 32'h38);
      check("ovf_no_req", {31'd0, mem_req}, 0);
      drained();

      // RET on empty stack
      do_reset();
      mem_arr[0] = mk(3'b101, 29'h0);
      fetch_q = '{0};
      start();
      wait_stop(20);
      repeat (3) @(negedge clk);
      check("unf_fault", {31'd0, fault}, 1);
      check("unf_ptr", ptr_addr, 0);
      drained();

      // Slow memory and slow execute unit
      do_reset();
      ack_delay = 4;
      exe_delay = 3;
      mem_arr[0] = mk(3'b000, 29'h1555);
      fetch_q = '{0, 1};
      exe_q   = '{mk(3'b000, 29'h1555)};
      ptr_q   = '{'{op: 3'b000, to: 0}};
      start();
      wait_stop(80);
      check("slow_halted", {31'd0, halted}, 1);
      drained();

      // Reset during WAIT, then a late ack must be ignored
      do_reset();
      ack_delay = 10;
      mem_arr[0] = mk(3'b000, 29'h77);
      start();
      @(negedge clk);
      check("wait_req", {31'd0, mem_req}, 1);
      nreset = 1'b0;
      #1;
      check("arst_mem_req", {31'd0, mem_req}, 0);
      @(negedge clk);
      force_ack = 1'b1;
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("late_mem_req", {31'd0, mem_req}, 0);
      check("late_exe_valid", {31'd0, exe_valid}, 0);
      check("late_halted", {31'd0, halted}, 0);
      check("late_fault", {31'd0, fault}, 0);
      check("late_opcode", {29'd0, ptr_opcode}, 3'b001);
      check("late_ptr", ptr_addr, 0);
      drained();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
